// File: rtl/wheel_pkg.sv
// wheel_pkg: shared state encoding and default sizes for the wheel state buffer.
//   Provides wheel_state_t (IDLE/RUN/COMMIT) and default NUM_NODES,
//   POSITION_SIZE, VELOCITY_SIZE and TIMEOUT_CYCLES values.
package wheel_pkg;

    localparam int NUM_NODES_DEF      = 8;
    localparam int POSITION_SIZE_DEF  = 16;
    localparam int VELOCITY_SIZE_DEF  = 16;
    localparam int TIMEOUT_CYCLES_DEF = 4096;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        COMMIT
    } wheel_state_t;

endpackage

// File: rtl/wheel_stream_capture.sv
// wheel_stream_capture: index counter and shadow (x,y) array for one streamed quantity.
//   clk_in/rst_in     clock, asynchronous active-low reset
//   clear             restart the write index at 0
//   load, load_data   overwrite the whole shadow array (takes priority over beats)
//   capture           beats are accepted only while high
//   valid, x, y       one streamed beat
//   shadow            captured array, [0]=x, [1]=y
//   idx               number of beats accepted since clear
//   overflow          a beat arrived with idx already at N and was discarded
module wheel_stream_capture
    import wheel_pkg::*;
#(
    parameter int N = NUM_NODES_DEF,
    parameter int W = POSITION_SIZE_DEF,
    localparam int IW = $clog2(N + 1),
    localparam int AW = $clog2(N)
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      clear,
    input  logic                      load,
    input  logic [1:0][N-1:0][W-1:0]  load_data,
    input  logic                      capture,
    input  logic                      valid,
    input  logic [W-1:0]              x,
    input  logic [W-1:0]              y,
    output logic [1:0][N-1:0][W-1:0]  shadow,
    output logic [IW-1:0]             idx,
    output logic                      overflow
);

    logic full;
    logic write;

    assign full     = idx == IW'(N);
    assign write    = capture && valid && !full;
    assign overflow = capture && valid && full;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            shadow <= '0;
            idx    <= '0;
        end else begin
            if (clear)
                idx <= '0;
            else if (write)
                idx <= idx + 1'b1;
            if (load)
                shadow <= load_data;
            else if (write) begin
                shadow[0][idx[AW-1:0]] <= x;
                shadow[1][idx[AW-1:0]] <= y;
            end
        end
    end

endmodule

// File: rtl/wheel_state_buffer.sv
// wheel_state_buffer: holds committed wheel node state and commits a streamed step atomically.
//   clk_in/rst_in                 clock, asynchronous active-low reset
//   init_in, init_nodes,
//   init_velocities               load initial state (IDLE only)
//   step_in / begin_out           step request / one-cycle launch pulse to the update stage
//   node_in_*, vel_in_*           streamed new positions and velocities
//   result_in                     step complete
//   nodes_out, velocities_out     committed arrays ([0]=x, [1]=y)
//   busy_out, loaded_out,
//   error_out, step_count_out     status
//   drop_count_out                saturating count of steps dropped while busy
//                                 (present only with WHEEL_STATE_DROP_CNT_EN)
module wheel_state_buffer
    import wheel_pkg::*;
#(
    parameter int NUM_NODES      = NUM_NODES_DEF,
    parameter int POSITION_SIZE  = POSITION_SIZE_DEF,
    parameter int VELOCITY_SIZE  = VELOCITY_SIZE_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                                          clk_in,
    input  logic                                          rst_in,
    input  logic                                          init_in,
    input  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]  init_nodes,
    input  logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]  init_velocities,
    input  logic                                          step_in,
    output logic                                          begin_out,
    input  logic [POSITION_SIZE-1:0]                      node_in_x,
    input  logic [POSITION_SIZE-1:0]                      node_in_y,
    input  logic                                          node_in_valid,
    input  logic [VELOCITY_SIZE-1:0]                      vel_in_x,
    input  logic [VELOCITY_SIZE-1:0]                      vel_in_y,
    input  logic                                          vel_in_valid,
    input  logic                                          result_in,
    output logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]  nodes_out,
    output logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]  velocities_out,
    output logic                                          busy_out,
    output logic                                          loaded_out,
    output logic                                          error_out,
    output logic [15:0]                                   step_count_out
`ifdef WHEEL_STATE_DROP_CNT_EN
    ,
    output logic [15:0]                                   drop_count_out
`endif
);

    localparam int IW = $clog2(NUM_NODES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    wheel_state_t state, state_nx;
    logic start, do_init, timeout, commit_ok, commit_bad, capture, reload;
    logic [IW-1:0] node_idx, vel_idx;
    logic node_ovf, vel_ovf;
    logic [TW-1:0] tmo;
    logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] shadow_nodes;
    logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] shadow_vels;

    always_comb begin
        start      = state == IDLE && step_in && loaded_out && !init_in;
        do_init    = state == IDLE && init_in;
        timeout    = state == RUN && !result_in && tmo == TW'(TIMEOUT_CYCLES - 1);
        commit_ok  = state == COMMIT && node_idx == IW'(NUM_NODES) && vel_idx == IW'(NUM_NODES);
        commit_bad = state == COMMIT && !commit_ok;
        capture    = state == RUN;
        // a timed-out step throws its partial shadow away by reloading the committed state
        reload     = do_init || timeout;
        state_nx   = state == IDLE ? (start ? RUN : IDLE)
                   : state == RUN  ? (result_in ? COMMIT : timeout ? IDLE : RUN)
                   : IDLE;
    end

    assign busy_out = state != IDLE;

    wheel_stream_capture #(.N(NUM_NODES), .W(POSITION_SIZE)) u_nodes (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear     (start),
        .load      (reload),
        .load_data (do_init ? init_nodes : nodes_out),
        .capture   (capture),
        .valid     (node_in_valid),
        .x         (node_in_x),
        .y         (node_in_y),
        .shadow    (shadow_nodes),
        .idx       (node_idx),
        .overflow  (node_ovf)
    );

    wheel_stream_capture #(.N(NUM_NODES), .W(VELOCITY_SIZE)) u_vels (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear     (start),
        .load      (reload),
        .load_data (do_init ? init_velocities : velocities_out),
        .capture   (capture),
        .valid     (vel_in_valid),
        .x         (vel_in_x),
        .y         (vel_in_y),
        .shadow    (shadow_vels),
        .idx       (vel_idx),
        .overflow  (vel_ovf)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= IDLE;
            begin_out      <= 1'b0;
            tmo            <= '0;
            nodes_out      <= '0;
            velocities_out <= '0;
            loaded_out     <= 1'b0;
            error_out      <= 1'b0;
            step_count_out <= '0;
        end else begin
            state     <= state_nx;
            begin_out <= start;
            tmo       <= start ? '0 : capture ? tmo + 1'b1 : tmo;
            if (do_init) begin
                nodes_out      <= init_nodes;
                velocities_out <= init_velocities;
                loaded_out     <= 1'b1;
                error_out      <= 1'b0;
                step_count_out <= '0;
            end
            if (commit_ok) begin
                nodes_out      <= shadow_nodes;
                velocities_out <= shadow_vels;
                step_count_out <= step_count_out + 1'b1;
            end
            if (node_ovf || vel_ovf || timeout || commit_bad)
                error_out <= 1'b1;
        end
    end

`ifdef WHEEL_STATE_DROP_CNT_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            drop_count_out <= '0;
        else if (do_init)
            drop_count_out <= '0;
        else if (step_in && busy_out && drop_count_out != 16'hffff)
            drop_count_out <= drop_count_out + 1'b1;
    end
`endif

endmodule

// File: tb/tb_wheel_state_buffer.sv
// tb_wheel_state_buffer: randomized self-checking bench for wheel_state_buffer against a
//   transaction-level model of committed state, error, step count and drops.
module tb_wheel_state_buffer;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int TO = 64;

    logic clk_in = 0;
    logic rst_in = 0;
    logic init_in = 0, step_in = 0, result_in = 0;
    logic node_in_valid = 0, vel_in_valid = 0;
    logic [W-1:0] node_in_x = 0, node_in_y = 0, vel_in_x = 0, vel_in_y = 0;
    logic [1:0][N-1:0][W-1:0] init_nodes = '0, init_velocities = '0;
    logic [1:0][N-1:0][W-1:0] nodes_out, velocities_out;
    logic begin_out, busy_out, loaded_out, error_out;
    logic [15:0] step_count_out;
`ifdef WHEEL_STATE_DROP_CNT_EN
    logic [15:0] drop_count_out;
`endif

    always #5 clk_in = ~clk_in;

    wheel_state_buffer #(
        .NUM_NODES(N), .POSITION_SIZE(W), .VELOCITY_SIZE(W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .init_in(init_in),
        .init_nodes(init_nodes), .init_velocities(init_velocities),
        .step_in(step_in), .begin_out(begin_out),
        .node_in_x(node_in_x), .node_in_y(node_in_y), .node_in_valid(node_in_valid),
        .vel_in_x(vel_in_x), .vel_in_y(vel_in_y), .vel_in_valid(vel_in_valid),
        .result_in(result_in), .nodes_out(nodes_out), .velocities_out(velocities_out),
        .busy_out(busy_out), .loaded_out(loaded_out), .error_out(error_out),
        .step_count_out(step_count_out)
`ifdef WHEEL_STATE_DROP_CNT_EN
        , .drop_count_out(drop_count_out)
`endif
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] m_pos [2][N];
    logic [15:0] m_vel [2][N];
    bit m_loaded = 0, m_err = 0;
    int m_count = 0, m_drops = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] pack(input logic [15:0] a [2][N]);
        logic [255:0] r = '0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++)
                r[(k*N+i)*16 +: 16] = a[k][i];
        return r;
    endfunction

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_static(input string tag, input bit busy);
        check({tag, ".nodes"}, nodes_out, pack(m_pos));
        check({tag, ".vels"}, velocities_out, pack(m_vel));
        check({tag, ".busy"}, busy_out, busy);
        check({tag, ".loaded"}, loaded_out, m_loaded);
        check({tag, ".error"}, error_out, m_err);
        check({tag, ".count"}, step_count_out, 16'(m_count));
`ifdef WHEEL_STATE_DROP_CNT_EN
        check({tag, ".drops"}, drop_count_out, 16'(m_drops));
`endif
    endtask

    task automatic do_init(input bit with_step);
        for (int i = 0; i < N; i++) begin
            m_pos[0][i] = 16'(10 * i);
            m_pos[1][i] = 16'(-5 * i);
            m_vel[0][i] = 16'd1;
            m_vel[1][i] = 16'd2;
            init_nodes[0][i] = m_pos[0][i];
            init_nodes[1][i] = m_pos[1][i];
            init_velocities[0][i] = m_vel[0][i];
            init_velocities[1][i] = m_vel[1][i];
        end
        init_in = 1;
        step_in = with_step;
        tick;
        init_in = 0;
        step_in = 0;
        m_loaded = 1;
        m_err = 0;
        m_count = 0;
        m_drops = 0;
        check("init.begin", begin_out, 0);
        check_static("init", 0);
    endtask

    task automatic run_step(input int np, input int nv, input int extra);
        logic [15:0] cp [2][N];
        logic [15:0] cv [2][N];
        int pc = 0, vc = 0, ps = 0, vs = 0, iter = 0;
        bit done = 0, pv, vv;
        cp = m_pos;
        cv = m_vel;
        step_in = 1;
        tick;
        step_in = 0;
        check("step.begin", begin_out, 1);
        check("step.busy", busy_out, 1);
        while (!done && iter < 500) begin
            pv = ps < np && $urandom_range(0, 2) != 0;
            vv = vs < nv && $urandom_range(0, 2) != 0;
            node_in_valid = pv;
            vel_in_valid = vv;
            node_in_x = 16'($urandom);
            node_in_y = 16'($urandom);
            vel_in_x = 16'($urandom);
            vel_in_y = 16'($urandom);
            if (pv) begin
                if (pc < N) begin
                    cp[0][pc] = node_in_x;
                    cp[1][pc] = node_in_y;
                    pc++;
                end else m_err = 1;
                ps++;
            end
            if (vv) begin
                if (vc < N) begin
                    cv[0][vc] = vel_in_x;
                    cv[1][vc] = vel_in_y;
                    vc++;
                end else m_err = 1;
                vs++;
            end
            result_in = ps == np && vs == nv && ($urandom_range(0, 1) == 1 || (!pv && !vv));
            step_in = iter < extra && !result_in;
            if (step_in) m_drops++;
            tick;
            done = result_in;
            check("run.begin", begin_out, 0);
            check("run.nodes_stable", nodes_out, pack(m_pos));
            check("run.busy", busy_out, 1);
            iter++;
        end
        {node_in_valid, vel_in_valid, result_in, step_in} = '0;
        check("step.finished", done, 1);
        tick;
        if (pc == N && vc == N) begin
            m_pos = cp;
            m_vel = cv;
            m_count++;
        end else m_err = 1;
        check_static("commit", 0);
    endtask

    initial begin
        tick;
        tick;
        check("rst.begin", begin_out, 0);
        check_static("rst", 0);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) begin
                m_pos[k][i] = 0;
                m_vel[k][i] = 0;
            end
        check_static("rst_arr", 0);
        rst_in = 1;
        tick;
        step_in = 1;
        tick;
        step_in = 0;
        check("unloaded.begin", begin_out, 0);
        check_static("unloaded", 0);
        do_init(1);
        tick;
        check("init_step.begin", begin_out, 0);
        run_step(8, 8, 0);
        run_step(8, 8, 3);
        for (int r = 0; r < 5; r++)
            run_step(8, 8, $urandom_range(0, 2));
        run_step(7, 8, 0);
        do_init(0);
        run_step(9, 8, 0);
        run_step(8, 10, 1);
        do_init(0);
        step_in = 1;
        tick;
        step_in = 0;
        check("tmo.begin", begin_out, 1);
        for (int c = 1; c < TO; c++) begin
            tick;
            check("tmo.busy", busy_out, 1);
        end
        tick;
        m_err = 1;
        check_static("tmo", 0);
        do_init(0);
        run_step(8, 8, 0);
        step_in = 1;
        tick;
        step_in = 0;
        node_in_valid = 1;
        vel_in_valid = 1;
        tick;
        tick;
        rst_in = 0;
        #1;
        check("rst_mid.nodes", nodes_out, 0);
        check("rst_mid.vels", velocities_out, 0);
        check("rst_mid.busy", busy_out, 0);
        check("rst_mid.loaded", loaded_out, 0);
        check("rst_mid.error", error_out, 0);
        check("rst_mid.count", step_count_out, 0);
        check("rst_mid.begin", begin_out, 0);
        node_in_valid = 0;
        vel_in_valid = 0;
        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
